// File: rtl/multiplexor_bcd.sv
// Multiplexed 7-segment driver: a sequential double-dabble converter turns N
// into BCD, and a refresh scanner walks the digits of the committed value.
//
// state     | meaning
// ----------+------------------------------------------------------------
// REPOSO    | sample N, clear the BCD and overflow scratch registers
// CONVERTIR | one add-3 / shift-left iteration per cycle, ANCHO_N cycles
// FIJAR     | commit the scratch BCD and overflow flag to the display side
module multiplexor_bcd #(
  parameter int ANCHO_N        = 8,
  parameter int DIGITOS        = 3,
  parameter int ANCHO_DISPLAYS = 8,
  parameter int DIV_REFRESCO   = 100_000
) (
  input  logic                      Reloj,
  input  logic                      Reset,
  input  logic [ANCHO_N-1:0]        N,
  input  logic                      Suprimir_ceros,
  input  logic [DIGITOS-1:0]        Puntos,
  output logic [ANCHO_DISPLAYS-1:0] Displays,
  output logic [7:0]                Segmentos,
  output logic                      Ocupado,
  output logic                      Desborde
);

  localparam int ANCHO_BCD  = 4 * DIGITOS;
  localparam int ANCHO_ITER = (ANCHO_N > 1) ? $clog2(ANCHO_N) : 1;
  localparam int ANCHO_CNT  = $clog2(DIV_REFRESCO);
  localparam int ANCHO_SEL  = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  typedef enum logic [1:0] {REPOSO, CONVERTIR, FIJAR} estado_t;

  estado_t                   estado, estado_sig;
  logic [ANCHO_N-1:0]        desp;
  logic [ANCHO_BCD-1:0]      bcd, bcd_aj, disp;
  logic [ANCHO_BCD:0]        bcd_desp;
  logic                      ovf;
  logic [ANCHO_ITER-1:0]     iter;
  logic [ANCHO_CNT-1:0]      cnt;
  logic [ANCHO_SEL-1:0]      sel;
  logic [DIGITOS-1:0]        cero_desde;
  logic                      acc, punto, cero, blanco;
  logic [3:0]                digito;
  logic [6:0]                seg7;
  logic [ANCHO_DISPLAYS-1:0] en;

  assign Ocupado = (estado != REPOSO);

  // State register
  always_ff @(posedge Reloj) begin
    if (Reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  // Next-state logic; the conversion ends when the iteration down-counter hits zero
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:    estado_sig = CONVERTIR;
      CONVERTIR: if (iter == '0) estado_sig = FIJAR;
      FIJAR:     estado_sig = REPOSO;
      default:   estado_sig = REPOSO;
    endcase
  end

  // Add 3 to every nibble >= 5, then append the next binary bit below the BCD
  always_comb begin
    bcd_aj = bcd;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_desp = {bcd_aj, desp[ANCHO_N-1]};
  end

  // Conversion datapath and committed display value
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      desp     <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      iter     <= '0;
      disp     <= '0;
      Desborde <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          desp <= N;
          bcd  <= '0;
          ovf  <= 1'b0;
          iter <= ANCHO_ITER'(ANCHO_N - 1);
        end
        CONVERTIR: begin
          desp <= desp << 1;
          bcd  <= bcd_desp[ANCHO_BCD-1:0];
          // A bit falling off the top nibble means the value needs more digits
          ovf  <= ovf | bcd_desp[ANCHO_BCD];
          iter <= iter - 1'b1;
        end
        FIJAR: begin
          disp     <= bcd;
          Desborde <= ovf;
        end
        default: ;
      endcase
    end
  end

  // Refresh timer and digit selector
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      cnt <= '0;
      sel <= '0;
    end else if (cnt == ANCHO_CNT'(DIV_REFRESCO - 1)) begin
      cnt <= '0;
      sel <= (sel == ANCHO_SEL'(DIGITOS - 1)) ? '0 : sel + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pick the selected digit, its decimal point and whether everything above it is zero
  always_comb begin
    acc        = 1'b1;
    cero_desde = '0;
    digito     = 4'd0;
    punto      = 1'b0;
    cero       = 1'b0;
    en         = '1;
    for (int i = DIGITOS - 1; i >= 0; i--) begin
      acc           = acc & (disp[4*i +: 4] == 4'd0);
      cero_desde[i] = acc;
    end
    for (int i = 0; i < DIGITOS; i++) begin
      if (sel == ANCHO_SEL'(i)) begin
        digito = disp[4*i +: 4];
        punto  = Puntos[i];
        cero   = cero_desde[i];
        en[i]  = 1'b0;
      end
    end
    blanco = Suprimir_ceros && (sel != '0) && cero;
  end

  // Segment pattern; overflow dash wins over blanking, which wins over the digit
  always_comb begin
    seg7 = 7'h7F;
    if (Desborde) seg7 = 7'h3F;
    else if (blanco) seg7 = 7'h7F;
    else begin
      case (digito)
        4'd0: seg7 = 7'h40;
        4'd1: seg7 = 7'h79;
        4'd2: seg7 = 7'h24;
        4'd3: seg7 = 7'h30;
        4'd4: seg7 = 7'h19;
        4'd5: seg7 = 7'h12;
        4'd6: seg7 = 7'h02;
        4'd7: seg7 = 7'h78;
        4'd8: seg7 = 7'h00;
        4'd9: seg7 = 7'h18;
        default: seg7 = 7'h7F;
      endcase
    end
  end

  // Registered pin drivers
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      Displays  <= '1;
      Segmentos <= 8'hFF;
    end else begin
      Displays  <= en;
      Segmentos <= {~punto, seg7};
    end
  end

endmodule

// File: tb/tb_multiplexor_bcd.sv
// Bench for multiplexor_bcd: a 3-digit and a 2-digit instance, expected
// segment bytes queued when N is driven and popped when the scan is checked.
module tb_multiplexor_bcd;

  logic       Reloj = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] N = 8'd0, N2 = 8'd0;
  logic       supp = 1'b0, supp2 = 1'b0;
  logic [2:0] pts = 3'b000;
  logic [1:0] pts2 = 2'b00;
  logic [7:0] Displays, Displays2, Segmentos, Segmentos2;
  logic       Ocupado, Ocupado2, Desborde, Desborde2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] e1[3];
  logic [7:0] e2[2];

  multiplexor_bcd #(.ANCHO_N(8), .DIGITOS(3), .ANCHO_DISPLAYS(8), .DIV_REFRESCO(4)) dut (
    .Reloj(Reloj), .Reset(Reset), .N(N), .Suprimir_ceros(supp), .Puntos(pts),
    .Displays(Displays), .Segmentos(Segmentos), .Ocupado(Ocupado), .Desborde(Desborde));

  multiplexor_bcd #(.ANCHO_N(8), .DIGITOS(2), .ANCHO_DISPLAYS(8), .DIV_REFRESCO(4)) dut2 (
    .Reloj(Reloj), .Reset(Reset), .N(N2), .Suprimir_ceros(supp2), .Puntos(pts2),
    .Displays(Displays2), .Segmentos(Segmentos2), .Ocupado(Ocupado2), .Desborde(Desborde2));

  always #5 Reloj = ~Reloj;

  // Edges since reset release; the digit on the pins is ((cyc-1)/4) mod DIGITOS
  always @(posedge Reloj) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] exp_byte(int n, int d, logic s, logic [7:0] p8, int i);
    int lim = 1;
    int pw = 1;
    int rest, dv;
    logic p;
    for (int k = 0; k < d; k++) lim *= 10;
    for (int k = 0; k < i; k++) pw *= 10;
    p = ~p8[i];
    rest = n % lim;
    dv = (rest / pw) % 10;
    if (n >= lim) return {p, 7'h3F};
    if (s && i > 0 && (rest / pw) == 0) return {p, 7'h7F};
    case (dv)
      0: return {p, 7'h40};
      1: return {p, 7'h79};
      2: return {p, 7'h24};
      3: return {p, 7'h30};
      4: return {p, 7'h19};
      5: return {p, 7'h12};
      6: return {p, 7'h02};
      7: return {p, 7'h78};
      8: return {p, 7'h00};
      default: return {p, 7'h18};
    endcase
  endfunction

  task automatic drive1(input int n, input logic s, input logic [2:0] p);
    @(negedge Reloj);
    N = n[7:0]; supp = s; pts = p;
    for (int i = 0; i < 3; i++) q1.push_back(exp_byte(n, 3, s, {5'b0, p}, i));
  endtask

  task automatic drive2(input int n);
    @(negedge Reloj);
    N2 = n[7:0];
    for (int i = 0; i < 2; i++) q2.push_back(exp_byte(n, 2, supp2, {6'b0, pts2}, i));
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Reloj);
    checks++; if (Displays !== 8'hFF || Segmentos !== 8'hFF) begin
      failures++; $display("FAIL reset_pins got=%h/%h exp=ff/ff", Displays, Segmentos); end
    checks++; if (Ocupado !== 1'b0 || Desborde !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=00", Ocupado, Desborde); end
    checks++; if (Displays2 !== 8'hFF || Segmentos2 !== 8'hFF || Ocupado2 !== 1'b0) begin
      failures++; $display("FAIL reset_dut2 got=%h/%h/%b exp=ff/ff/0", Displays2, Segmentos2, Ocupado2); end
    Reset = 1'b0;
    @(negedge Reloj);
    checks++; if (Displays !== 8'hFE || Segmentos !== 8'hC0) begin
      failures++; $display("FAIL first_after_reset got=%h/%h exp=fe/c0", Displays, Segmentos); end
  endtask

  task automatic test_busy();
    int k, hi, lo;
    k = 0; while (Ocupado !== 1'b0 && k < 30) begin @(negedge Reloj); k++; end
    k = 0; while (Ocupado !== 1'b1 && k < 30) begin @(negedge Reloj); k++; end
    checks++; if (Ocupado !== 1'b1) begin
      failures++; $display("FAIL busy_timeout got=%b exp=1", Ocupado); end
    hi = 0; while (Ocupado === 1'b1 && hi < 40) begin hi++; @(negedge Reloj); end
    lo = 0; while (Ocupado === 1'b0 && lo < 40) begin lo++; @(negedge Reloj); end
    checks++; if (hi != 9) begin failures++; $display("FAIL busy_high got=%0d exp=9", hi); end
    checks++; if (lo != 1) begin failures++; $display("FAIL busy_low got=%0d exp=1", lo); end
  endtask

  task automatic test_scan_125();
    int dig;
    drive1(125, 1'b0, 3'b000);
    repeat (24) @(negedge Reloj);
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    for (int c = 0; c < 24; c++) begin
      @(negedge Reloj);
      dig = ((cyc - 1) / 4) % 3;
      checks++; if (Displays !== ~(8'h01 << dig)) begin
        failures++; $display("FAIL scan125_displays got=%h exp=%h", Displays, ~(8'h01 << dig)); end
      checks++; if (Segmentos !== e1[dig]) begin
        failures++; $display("FAIL scan125_seg got=%h exp=%h", Segmentos, e1[dig]); end
    end
    checks++; if (Desborde !== 1'b0) begin
      failures++; $display("FAIL scan125_desborde got=%b exp=0", Desborde); end
  endtask

  task automatic test_suppress();
    int dig;
    drive1(0, 1'b1, 3'b000);
    drive1(7, 1'b1, 3'b010);
    // N=7 overwrote N=0 one cycle later; wait for the 0 setting to be superseded
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    repeat (24) @(negedge Reloj);
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    for (int c = 0; c < 12; c++) begin
      @(negedge Reloj);
      dig = ((cyc - 1) / 4) % 3;
      checks++; if (Segmentos !== e1[dig]) begin
        failures++; $display("FAIL supp7_seg digit=%0d got=%h exp=%h", dig, Segmentos, e1[dig]); end
    end
    drive1(0, 1'b1, 3'b000);
    repeat (24) @(negedge Reloj);
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    for (int c = 0; c < 12; c++) begin
      @(negedge Reloj);
      dig = ((cyc - 1) / 4) % 3;
      checks++; if (Segmentos !== e1[dig]) begin
        failures++; $display("FAIL supp0_seg digit=%0d got=%h exp=%h", dig, Segmentos, e1[dig]); end
    end
  endtask

  task automatic test_overflow();
    int dig;
    for (int t = 0; t < 2; t++) begin
      drive2(t == 0 ? 255 : 99);
      repeat (24) @(negedge Reloj);
      for (int i = 0; i < 2; i++) e2[i] = q2.pop_front();
      checks++; if (Desborde2 !== (t == 0)) begin
        failures++; $display("FAIL ovf_flag step=%0d got=%b exp=%b", t, Desborde2, t == 0); end
      for (int c = 0; c < 8; c++) begin
        @(negedge Reloj);
        dig = ((cyc - 1) / 4) % 2;
        checks++; if (Displays2 !== ~(8'h01 << dig) || Segmentos2 !== e2[dig]) begin
          failures++;
          $display("FAIL ovf_scan step=%0d got=%h/%h exp=%h/%h", t, Displays2, Segmentos2, ~(8'h01 << dig), e2[dig]);
        end
      end
    end
  endtask

  task automatic test_n_change();
    int k, dig;
    drive1(4, 1'b0, 3'b000);
    k = 0; while (Ocupado !== 1'b0 && k < 30) begin @(negedge Reloj); k++; end
    k = 0; while (Ocupado !== 1'b1 && k < 30) begin @(negedge Reloj); k++; end
    repeat (2) @(negedge Reloj);
    drive1(169, 1'b0, 3'b000);
    k = 0; while (Ocupado !== 1'b0 && k < 30) begin @(negedge Reloj); k++; end
    checks++; if (Ocupado !== 1'b0) begin
      failures++; $display("FAIL nchg_timeout got=%b exp=0", Ocupado); end
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    for (int c = 0; c < 10; c++) begin
      @(negedge Reloj);
      dig = ((cyc - 1) / 4) % 3;
      checks++; if (Segmentos !== e1[dig]) begin
        failures++; $display("FAIL nchg_first digit=%0d got=%h exp=%h", dig, Segmentos, e1[dig]); end
    end
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    repeat (2) @(negedge Reloj);
    for (int c = 0; c < 12; c++) begin
      @(negedge Reloj);
      dig = ((cyc - 1) / 4) % 3;
      checks++; if (Segmentos !== e1[dig]) begin
        failures++; $display("FAIL nchg_second digit=%0d got=%h exp=%h", dig, Segmentos, e1[dig]); end
    end
  endtask

  task automatic test_reset_mid();
    int k, dig;
    k = 0; while (Ocupado !== 1'b0 && k < 30) begin @(negedge Reloj); k++; end
    k = 0; while (Ocupado !== 1'b1 && k < 30) begin @(negedge Reloj); k++; end
    repeat (3) @(negedge Reloj);
    Reset = 1'b1;
    @(negedge Reloj);
    checks++; if (Displays !== 8'hFF || Segmentos !== 8'hFF || Ocupado !== 1'b0) begin
      failures++; $display("FAIL rstmid_pins got=%h/%h/%b exp=ff/ff/0", Displays, Segmentos, Ocupado); end
    checks++; if (Displays2 !== 8'hFF || Desborde !== 1'b0) begin
      failures++; $display("FAIL rstmid_dut2 got=%h/%b exp=ff/0", Displays2, Desborde); end
    N = 8'd42; supp = 1'b0; pts = 3'b000;
    for (int i = 0; i < 3; i++) q1.push_back(exp_byte(42, 3, 1'b0, 8'h00, i));
    Reset = 1'b0;
    @(negedge Reloj);
    checks++; if (Displays !== 8'hFE || Segmentos !== 8'hC0 || Ocupado !== 1'b1) begin
      failures++; $display("FAIL rstmid_restart got=%h/%h/%b exp=fe/c0/1", Displays, Segmentos, Ocupado); end
    k = 0; while (Ocupado !== 1'b0 && k < 30) begin @(negedge Reloj); k++; end
    checks++; if (cyc != 10) begin
      failures++; $display("FAIL rstmid_commit_cycle got=%0d exp=10", cyc); end
    for (int i = 0; i < 3; i++) e1[i] = q1.pop_front();
    @(negedge Reloj);
    for (int c = 0; c < 12; c++) begin
      @(negedge Reloj);
      dig = ((cyc - 1) / 4) % 3;
      checks++; if (Segmentos !== e1[dig]) begin
        failures++; $display("FAIL rstmid_value digit=%0d got=%h exp=%h", dig, Segmentos, e1[dig]); end
    end
  endtask

  initial begin
    test_reset();
    test_busy();
    test_scan_125();
    test_suppress();
    test_overflow();
    test_n_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
